// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation codes,
// FSM state encoding, default width and small decode helpers.
package ex_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    // Divide family (DIV, DIVU, REM, REMU).
    function automatic logic is_div(input funct3_e f);
        return (f == F3_DIV) || (f == F3_DIVU) || (f == F3_REM) || (f == F3_REMU);
    endfunction

    // Remainder flavours return the remainder instead of the quotient.
    function automatic logic is_rem(input funct3_e f);
        return (f == F3_REM) || (f == F3_REMU);
    endfunction

    // rs1 is interpreted as two's complement.
    function automatic logic signed_rs1(input funct3_e f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    // rs2 is interpreted as two's complement.
    function automatic logic signed_rs2(input funct3_e f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step.
// The quotient register starts out holding the dividend and is shifted left
// while quotient bits are shifted in from the right.
module md_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    // Trial subtraction of the divisor from the shifted partial remainder.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
        rem_nxt = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_nxt = trial[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    // Load operands on start, retire one bit per step.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else if (load) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvsr_q <= divisor;
        end else if (step) begin
            rem_q  <= rem_nxt;
            quo_q  <= quo_nxt;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit. Operands are reduced to magnitudes on entry,
// multiplied (shift-add, MUL_BPC bits per cycle) or divided (restoring, one
// bit per cycle), then the recorded sign is applied in a single FIX cycle.
// Divide by zero and signed overflow bypass the datapath and finish at once.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_ex,
    input  logic            cpu_stat_ex,
    input  logic [2:0]      funct3_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic [4:0]      rd_adr_ex,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [4:0]      rd_adr_md,
    output logic [XLEN-1:0] rd_data_md
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_BPC - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_e                  state, state_nxt;
    funct3_e                 f3_in, op;
    logic                    rs1_neg, rs2_neg, neg_in, neg;
    logic [XLEN-1:0]         rs1_mag, rs2_mag;
    logic                    div_zero, div_ovf;
    logic [XLEN-1:0]         special_res;
    logic                    load_op, load_out, calc_last;
    logic [XLEN-1:0]         out_data;
    logic [4:0]              out_rd;
    logic [4:0]              rd_q;
    logic [CW-1:0]           cnt;
    logic [XLEN-1:0]         mcand;
    logic [2*XLEN-1:0]       prod, prod_nxt, prod_signed;
    logic [XLEN+MUL_BPC-1:0] mul_part, mul_sum;
    logic [XLEN-1:0]         quo, rem, quo_signed, rem_signed, fix_res;

    // Decode the incoming request: magnitudes, result sign and early-exit cases.
    always_comb begin
        f3_in    = funct3_e'(funct3_ex);
        rs1_neg  = signed_rs1(f3_in) & rs1_data_ex[XLEN-1];
        rs2_neg  = signed_rs2(f3_in) & rs2_data_ex[XLEN-1];
        rs1_mag  = rs1_neg ? -rs1_data_ex : rs1_data_ex;
        rs2_mag  = rs2_neg ? -rs2_data_ex : rs2_data_ex;
        // Remainder takes the dividend's sign; everything else the XOR of both.
        neg_in   = is_rem(f3_in) ? rs1_neg : (rs1_neg ^ rs2_neg);
        div_zero = is_div(f3_in) && (rs2_data_ex == '0);
        div_ovf  = is_div(f3_in) && signed_rs2(f3_in) &&
                   (rs1_data_ex == INT_MIN) && (rs2_data_ex == '1);
        if (div_zero) special_res = is_rem(f3_in) ? rs1_data_ex : '1;
        else          special_res = is_rem(f3_in) ? '0 : rs1_data_ex;
    end

    // One shift-add step: add mcand times the low MUL_BPC multiplier bits, shift right.
    always_comb begin
        mul_part = '0;
        for (int i = 0; i < MUL_BPC; i++) begin
            if (prod[i]) mul_part = mul_part + ({{MUL_BPC{1'b0}}, mcand} << i);
        end
        mul_sum  = {{MUL_BPC{1'b0}}, prod[2*XLEN-1:XLEN]} + mul_part;
        prod_nxt = {mul_sum, prod[XLEN-1:MUL_BPC]};
    end

    // Apply the recorded sign and pick the architectural result word.
    always_comb begin
        prod_signed = neg ? -prod : prod;
        quo_signed  = neg ? -quo : quo;
        rem_signed  = neg ? -rem : rem;
        if (is_div(op))        fix_res = is_rem(op) ? rem_signed : quo_signed;
        else if (op == F3_MUL) fix_res = prod_signed[XLEN-1:0];
        else                   fix_res = prod_signed[2*XLEN-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, datapath strobes and handshake outputs; flush overrides all.
    always_comb begin
        state_nxt = state;
        load_op   = 1'b0;
        load_out  = 1'b0;
        out_data  = fix_res;
        out_rd    = rd_q;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        calc_last = (cnt == (is_div(op) ? DIV_LAST : MUL_LAST));
        case (state)
            S_IDLE: begin
                if (start_ex && cpu_stat_ex) begin
                    if (div_zero || div_ovf) begin
                        load_out  = 1'b1;
                        out_data  = special_res;
                        out_rd    = rd_adr_ex;
                        state_nxt = S_DONE;
                    end else begin
                        load_op   = 1'b1;
                        state_nxt = S_CALC;
                    end
                end
            end
            S_CALC:  if (calc_last) state_nxt = S_FIX;
            S_FIX: begin
                load_out  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            load_op   = 1'b0;
            load_out  = 1'b0;
        end
        stall_req = (start_ex & cpu_stat_ex & (state == S_IDLE)) | (busy & ~done);
    end

    // Operation context and multiply datapath; the cycle counter runs during CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= F3_MUL;
            rd_q  <= '0;
            neg   <= 1'b0;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else if (load_op) begin
            op    <= f3_in;
            rd_q  <= rd_adr_ex;
            neg   <= neg_in;
            mcand <= rs1_mag;
            prod  <= {{XLEN{1'b0}}, rs2_mag};
            cnt   <= '0;
        end else if (state == S_CALC) begin
            cnt <= cnt + CW'(1);
            if (!is_div(op)) prod <= prod_nxt;
        end
    end

    md_div_core #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_op && is_div(f3_in)),
        .step     ((state == S_CALC) && is_div(op)),
        .dividend (rs1_mag),
        .divisor  (rs2_mag),
        .quotient (quo),
        .remainder(rem)
    );

    // Result registers: updated only when a result is produced, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_md <= '0;
            rd_adr_md  <= '0;
        end else if (load_out) begin
            rd_data_md <= out_data;
            rd_adr_md  <= out_rd;
        end
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width.
REQ-002 Parameter MUL_BPC, default 1, SHALL set the multiplier bits retired per cycle; legal values are 1, 2 and 4, and the value SHALL divide XLEN.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start_ex  in  1  request valid for one cycle; qualified by cpu_stat_ex.
REQ-006 cpu_stat_ex  in  1  EX stage is executing.
REQ-007 funct3_ex  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 rs1_data_ex, rs2_data_ex  in  XLEN each  operands.
REQ-009 rd_adr_ex  in  5  destination register.
REQ-010 flush  in  1  kill the operation in flight (jump or exception).
REQ-011 busy  out  1  an operation is in flight.
REQ-012 stall_req  out  1  hold IF/ID/EX; equals (start_ex & cpu_stat_ex & idle) | (busy & ~done).
REQ-013 done  out  1  result valid, 1-cycle pulse.
REQ-014 rd_adr_md  out  5  destination register, valid while done is high.
REQ-015 rd_data_md  out  XLEN  result, valid while done is high.

Function
REQ-016 The block SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-017 In IDLE, start_ex & cpu_stat_ex & ~flush at cycle T SHALL latch the operands, funct3 and rd into registers.
- Operands are converted to magnitudes per signedness: MULH signs both, MULHSU signs rs1 only, DIV/REM sign both, the rest unsigned.
- The result sign is recorded.
- State goes to CALC.
REQ-018 In CALC, the multiply SHALL shift-add MUL_BPC bits per cycle for N = XLEN/MUL_BPC cycles.
REQ-019 In CALC, the divide SHALL restoring shift-subtract 1 bit per cycle for N = XLEN cycles.
REQ-020 FIX SHALL apply the result sign in 1 cycle and select the output word.
- MUL takes the low XLEN bits of the 2·XLEN product.
- MULH, MULHSU and MULHU take the high XLEN bits.
- Remainder sign follows the dividend.
REQ-021 DONE SHALL assert done for one cycle and then return to IDLE, so done occurs at T+N+2.
REQ-022 Divide by zero SHALL skip CALC/FIX and give done at T+1.
- DIV/DIVU result is all ones.
- REM/REMU result is rs1.
REQ-023 Signed overflow (DIV/REM with rs1 = -2^(XLEN-1) and rs2 = -1) SHALL give done at T+1.
- DIV result is rs1.
- REM result is 0.
REQ-024 start_ex while busy SHALL be ignored.
REQ-025 flush in any state SHALL force IDLE on the next edge with no done; flush together with start_ex SHALL mean no operation starts.
REQ-026 rd_data_md and rd_adr_md SHALL hold their last value when done is low.
REQ-027 MUL with MUL_BPC>1 SHALL produce results bit-identical to MUL_BPC=1.

Reset
REQ-028 While rst_n is low, state SHALL be IDLE and busy, done, stall_req, rd_adr_md and rd_data_md SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no done after release.

Structure
REQ-030 Package ex_muldiv_pkg SHALL hold the funct3 codes, the state encoding and the XLEN default.
REQ-031 The divide datapath (remainder/quotient shift-subtract) SHALL be sub-module md_div_core; the multiply datapath and sign handling SHALL stay in ex_muldiv.

Verification (XLEN=32, MUL_BPC=1 unless stated)
REQ-032 MUL 7×6 at T -> done at T+34, rd_data_md = 42; repeated with MUL_BPC=4 -> done at T+10, rd_data_md = 42.
REQ-033 MULH 0x80000000×0x80000000 -> rd_data_md = 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 DIV -7/2 -> 0xFFFFFFFD and REM -7%2 -> 0xFFFFFFFF, each with done at T+34.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; all with done at T+1.
REQ-036 flush at T+10 of a DIV -> busy=0 at T+11, no done, and a new MUL 3×3 issued at T+12 -> 9 at T+46.
REQ-037 rst_n low at T+5 of a MUL -> outputs 0 and no done after release.
